register_file_ctx: RTL and testbench
====================================

REGISTER_FILE_CTX -- requirements
Module: register_file_ctx

Interface
REQ-001 Parameter DATA_W, default 16, data width of every register, minimum 1.
REQ-002 Parameter NUM_REGS, default 8, register count, power of two, minimum 2; AW = log2(NUM_REGS).
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low.
REQ-005 Port wr_en  in  1  write strobe for the main bank.
REQ-006 Port wr_addr  in  AW  write index.
REQ-007 Port wr_data  in  DATA_W  write data.
REQ-008 Port rd_en_a / rd_en_b  in  1 each  read enables, ports A and B.
REQ-009 Port rd_addr_a / rd_addr_b  in  AW each  read indices.
REQ-010 Port rd_data_a / rd_data_b  out  DATA_W each  read data.
REQ-011 Port ctx_op  in  2  context operation: 01 save, 10 restore, 00 and 11 no-op.
REQ-012 Port ctx_req  in  1  context request, sampled only in IDLE.
REQ-013 Port ctx_busy  out  1  high while a save or restore copy is in progress.
REQ-014 Port ctx_done  out  1  one-cycle completion pulse.

Function
REQ-015 Main bank and shadow bank SHALL each hold NUM_REGS registers of DATA_W bits.
REQ-016 Reads SHALL be combinational: rd_data_x = main[rd_addr_x] when rd_en_x = 1, else all zeros.
REQ-017 A write SHALL update main[wr_addr] at the clock edge when wr_en = 1 and ctx_busy = 0; when ctx_busy = 1 the write SHALL be dropped silently.
REQ-018 The FSM SHALL have four states: IDLE, SAVE, RESTORE, DONE.
REQ-019 In IDLE, ctx_req = 1 with ctx_op = 01 SHALL go to SAVE, with ctx_op = 10 SHALL go to RESTORE; any other combination SHALL stay in IDLE.
REQ-020 In SAVE, each cycle SHALL copy main[idx] to shadow[idx], with idx running 0 to NUM_REGS-1; RESTORE SHALL copy shadow[idx] to main[idx] the same way.
REQ-021 After the copy of idx = NUM_REGS-1 the FSM SHALL enter DONE for exactly one cycle and then return to IDLE.
REQ-022 ctx_busy SHALL be 1 exactly in SAVE and RESTORE; ctx_done SHALL be 1 exactly in DONE.
REQ-023 A request accepted at edge k SHALL give busy over cycles k+1 .. k+NUM_REGS and done in cycle k+NUM_REGS+1.
REQ-024 ctx_req in SAVE, RESTORE or DONE SHALL be ignored, with no queuing.
REQ-025 During RESTORE, reads SHALL return the main-bank contents of the current cycle: restored values for indices below idx, old values for the rest.
REQ-026 The idx counter SHALL wrap to 0 on leaving DONE.

Reset
REQ-027 On rst = 0, both banks, idx and the FSM SHALL clear immediately (FSM to IDLE), regardless of clock.
REQ-028 During reset, ctx_busy and ctx_done SHALL be 0, and rd_data_x SHALL be 0.
REQ-029 Reset asserted mid-save or mid-restore SHALL abort the operation with no done pulse.

Configuration
REQ-030 Macro RF_BYPASS_EN SHALL select write-to-read forwarding.
REQ-031 With RF_BYPASS_EN defined, rd_data_x SHALL equal wr_data when rd_en_x = 1, wr_en = 1, ctx_busy = 0 and rd_addr_x = wr_addr.
REQ-032 Without RF_BYPASS_EN, a same-cycle read SHALL return the pre-write stored value.

Structure
REQ-033 Shared package register_file_pkg SHALL hold the ctx_op encodings (CTX_NOP, CTX_SAVE, CTX_RESTORE) and the FSM state encodings.
REQ-034 Sub-module ctx_sequencer SHALL contain the FSM, the idx counter and ctx_busy/ctx_done, and SHALL drive copy-enable and direction to the banks.

Verification (DATA_W = 16, NUM_REGS = 8)
REQ-035 Write 0xA5A5 to r3, read r3 on A and r3 on B -> both 0xA5A5; rd_en_a = 0 -> rd_data_a = 0x0000.
REQ-036 Write r0..r7 = 0x1000+i, save, overwrite all with 0xBEEF, restore -> r5 reads 0x1005; busy high 8 cycles per operation; one done pulse each.
REQ-037 During save, wr_en to r2 with 0xFACE -> write dropped; r2 keeps its old value after save and after restore.
REQ-038 wr_en r4 = 0x1234 with same-cycle read of r4 -> 0x1234 with RF_BYPASS_EN, old value without.
REQ-039 Assert rst at the 4th restore cycle -> all reads 0x0000, busy = 0, no done pulse; a later restore yields zeros.
REQ-040 ctx_req with ctx_op = 11, and a second ctx_req while busy -> no state change, no extra done pulse.

Source files
------------

// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_pkg
//  Description : Shared encodings for the context-switching register file:
//                ctx_op commands, sequencer state codes, copy direction.
//  Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    // Context operation commands carried on ctx_op
    localparam logic [1:0] CTX_NOP     = 2'b00;
    localparam logic [1:0] CTX_SAVE    = 2'b01;
    localparam logic [1:0] CTX_RESTORE = 2'b10;

    // Sequencer states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SAVE    = 2'd1;
    localparam logic [1:0] ST_RESTORE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Copy direction between the banks
    localparam logic COPY_DIR_SAVE    = 1'b0;   // main   -> shadow
    localparam logic COPY_DIR_RESTORE = 1'b1;   // shadow -> main

endpackage
`default_nettype wire

// File: rtl/ctx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ctx_sequencer
//  Description : Save/restore sequencer. Walks an index over every register
//                one per cycle, then emits a single-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctx_sequencer
    import register_file_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,        // asynchronous, active-low
    input  logic          ctx_req,
    input  logic [1:0]    ctx_op,
    output logic          ctx_busy,
    output logic          ctx_done,
    output logic          copy_en,
    output logic          copy_dir,
    output logic [AW-1:0] copy_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q,   idx_d;

    // Next-state and index logic; requests are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (ctx_req) begin
                    case (ctx_op)
                        CTX_SAVE:    state_d = ST_SAVE;
                        CTX_RESTORE: state_d = ST_RESTORE;
                        CTX_NOP:     state_d = ST_IDLE;
                        default:     state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SAVE, ST_RESTORE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and index registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Status and copy controls decoded straight from the state
    always_comb begin
        ctx_busy = (state_q == ST_SAVE) || (state_q == ST_RESTORE);
        ctx_done = (state_q == ST_DONE);
        copy_en  = ctx_busy;
        copy_dir = (state_q == ST_RESTORE) ? COPY_DIR_RESTORE : COPY_DIR_SAVE;
        copy_idx = idx_q;
    end

endmodule
`default_nettype wire

// File: rtl/register_file_ctx.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_ctx
//  Description : Two-read/one-write register file with a shadow bank and
//                a sequenced save/restore of the full context.
//                Define RF_BYPASS_EN to forward same-cycle write data to
//                matching reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_ctx
    import register_file_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 8,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic              rd_en_b,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [1:0]        ctx_op,
    input  logic              ctx_req,
    output logic              ctx_busy,
    output logic              ctx_done
);

    logic [DATA_W-1:0] main_q   [NUM_REGS];
    logic [DATA_W-1:0] main_d   [NUM_REGS];
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];

    logic          copy_en;
    logic          copy_dir;
    logic [AW-1:0] copy_idx;
    logic          wr_accept;

    ctx_sequencer #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .ctx_req  (ctx_req),
        .ctx_op   (ctx_op),
        .ctx_busy (ctx_busy),
        .ctx_done (ctx_done),
        .copy_en  (copy_en),
        .copy_dir (copy_dir),
        .copy_idx (copy_idx)
    );

    // Host writes are discarded while a context copy owns the banks
    assign wr_accept = wr_en && !ctx_busy;

    // Bank update: one copy slot per cycle, or a host write when idle
    always_comb begin
        main_d   = main_q;
        shadow_d = shadow_q;
        if (copy_en) begin
            if (copy_dir == COPY_DIR_RESTORE) begin
                main_d[copy_idx] = shadow_q[copy_idx];
            end else begin
                shadow_d[copy_idx] = main_q[copy_idx];
            end
        end else if (wr_accept) begin
            main_d[wr_addr] = wr_data;
        end
    end

    // Both banks clear asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                main_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            main_q   <= main_d;
            shadow_q <= shadow_d;
        end
    end

    // Combinational read ports; reset forces zero even with forwarding on
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rst) begin
            if (rd_en_a) rd_data_a = main_q[rd_addr_a];
            if (rd_en_b) rd_data_b = main_q[rd_addr_b];
`ifdef RF_BYPASS_EN
            if (rd_en_a && wr_accept && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
            if (rd_en_b && wr_accept && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_ctx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_ctx
//  Description : Self-checking bench for register_file_ctx (16 x 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_ctx;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int AW       = 3;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en_a = 1'b0;
    logic [AW-1:0]     rd_addr_a = '0;
    logic              rd_en_b = 1'b0;
    logic [AW-1:0]     rd_addr_b = '0;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [1:0]        ctx_op = 2'b00;
    logic              ctx_req = 1'b0;
    logic              ctx_busy;
    logic              ctx_done;

    always #5 clk = ~clk;

    register_file_ctx #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .ctx_op    (ctx_op),
        .ctx_req   (ctx_req),
        .ctx_busy  (ctx_busy),
        .ctx_done  (ctx_done)
    );

    int checks = 0;
    int errors = 0;
    int busy_seen = 0;
    int done_seen = 0;

    // Reference model: register contents plus "copies still to do" counter
    logic [DATA_W-1:0] m_main   [NUM_REGS];
    logic [DATA_W-1:0] m_shadow [NUM_REGS];
    int m_left    = 0;
    bit m_restore = 1'b0;
    bit m_done    = 1'b0;

    typedef struct {
        logic              we;
        logic [AW-1:0]     wa;
        logic [DATA_W-1:0] wd;
        logic              ea;
        logic [AW-1:0]     aa;
        logic              eb;
        logic [AW-1:0]     ab;
        logic [DATA_W-1:0] xa;
        logic [DATA_W-1:0] xb;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_main[i]   = '0;
            m_shadow[i] = '0;
        end
        m_left    = 0;
        m_restore = 1'b0;
        m_done    = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic en, input logic [AW-1:0] a);
        if (!rst || !en) return '0;
        if (BYP && wr_en && (m_left == 0) && (a == wr_addr)) return wr_data;
        return m_main[a];
    endfunction

    // Effect of one rising edge on the reference model
    task automatic model_edge();
        int idx;
        if (m_left == 0 && wr_en) m_main[wr_addr] = wr_data;
        if (m_left > 0) begin
            idx = NUM_REGS - m_left;
            if (m_restore) m_main[idx] = m_shadow[idx];
            else           m_shadow[idx] = m_main[idx];
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (ctx_req && ctx_op == 2'b01) begin
            m_left = NUM_REGS; m_restore = 1'b0;
        end else if (ctx_req && ctx_op == 2'b10) begin
            m_left = NUM_REGS; m_restore = 1'b1;
        end
    endtask

    task automatic drive(input logic we, input int wa, input logic [DATA_W-1:0] wd,
                         input logic ea, input int aa, input logic eb, input int ab,
                         input logic req, input logic [1:0] op);
        wr_en = we; wr_addr = AW'(wa); wr_data = wd;
        rd_en_a = ea; rd_addr_a = AW'(aa);
        rd_en_b = eb; rd_addr_b = AW'(ab);
        ctx_req = req; ctx_op = op;
    endtask

    task automatic idle();
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b0, 2'b00);
    endtask

    // One clock: compare all outputs at the falling edge, advance the model
    task automatic step(input string tag);
        @(negedge clk);
        chk({tag, " rd_a"}, 32'(rd_data_a), 32'(exp_rd(rd_en_a, rd_addr_a)));
        chk({tag, " rd_b"}, 32'(rd_data_b), 32'(exp_rd(rd_en_b, rd_addr_b)));
        chk({tag, " busy"}, 32'(ctx_busy), 32'(m_left > 0));
        chk({tag, " done"}, 32'(ctx_done), 32'(m_done));
        busy_seen += int'(ctx_busy);
        done_seen += int'(ctx_done);
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic run_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 0, '0, 1'b1, int'($urandom_range(0, 7)), 1'b1, int'($urandom_range(0, 7)), 1'b0, 2'b00);
            step(tag);
        end
    endtask

    initial begin
        model_clear();

        // Reset state: everything zero while rst is low
        drive(1'b1, 3, 16'h5555, 1'b1, 3, 1'b1, 3, 1'b0, 2'b00);
        #2;
        chk("reset rd_a", 32'(rd_data_a), 32'h0);
        chk("reset rd_b", 32'(rd_data_b), 32'h0);
        chk("reset busy", 32'(ctx_busy), 32'h0);
        chk("reset done", 32'(ctx_done), 32'h0);
        idle();
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven basic write/read vectors
        tbl[0] = '{1'b1, 3'd3, 16'hA5A5, 1'b1, 3'd3, 1'b1, 3'd3,
                   BYP ? 16'hA5A5 : 16'h0000, BYP ? 16'hA5A5 : 16'h0000};
        tbl[1] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd3, 16'hA5A5, 16'hA5A5};
        tbl[2] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 1'b1, 3'd3, 16'h0000, 16'hA5A5};
        tbl[3] = '{1'b1, 3'd4, 16'h1234, 1'b1, 3'd4, 1'b1, 3'd3,
                   BYP ? 16'h1234 : 16'h0000, 16'hA5A5};
        tbl[4] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b1, 3'd0, 16'h1234, 16'h0000};
        tbl[5] = '{1'b1, 3'd4, 16'h5678, 1'b1, 3'd4, 1'b1, 3'd4,
                   BYP ? 16'h5678 : 16'h1234, BYP ? 16'h5678 : 16'h1234};
        tbl[6] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b1, 3'd4, 16'h5678, 16'h5678};
        for (int v = 0; v < 7; v++) begin
            drive(tbl[v].we, int'(tbl[v].wa), tbl[v].wd, tbl[v].ea, int'(tbl[v].aa),
                  tbl[v].eb, int'(tbl[v].ab), 1'b0, 2'b00);
            #3;
            chk($sformatf("tbl%0d a", v), 32'(rd_data_a), 32'(tbl[v].xa));
            chk($sformatf("tbl%0d b", v), 32'(rd_data_b), 32'(tbl[v].xb));
            step($sformatf("tbl%0d", v));
        end

        // Fill, save, clobber, restore
        for (int i = 0; i < NUM_REGS; i++) begin
            drive(1'b1, i, 16'h1000 + 16'(i), 1'b1, i, 1'b0, 0, 1'b0, 2'b00);
            step("fill");
        end
        busy_seen = 0; done_seen = 0;
        drive(1'b0, 0, '0, 1'b1, 0, 1'b1, 7, 1'b1, 2'b01);
        step("save req");
        run_idle("save", 12);
        chk("save busy cycles", 32'(busy_seen), 32'd8);
        chk("save done pulses", 32'(done_seen), 32'd1);
        for (int i = 0; i < NUM_REGS; i++) begin
            drive(1'b1, i, 16'hBEEF, 1'b1, i, 1'b0, 0, 1'b0, 2'b00);
            step("clobber");
        end
        busy_seen = 0; done_seen = 0;
        drive(1'b0, 0, '0, 1'b1, 5, 1'b1, 2, 1'b1, 2'b10);
        step("restore req");
        run_idle("restore", 12);
        chk("restore busy cycles", 32'(busy_seen), 32'd8);
        chk("restore done pulses", 32'(done_seen), 32'd1);
        drive(1'b0, 0, '0, 1'b1, 5, 1'b0, 0, 1'b0, 2'b00);
        #3;
        chk("r5 restored", 32'(rd_data_a), 32'h1005);
        step("r5");

        // Write during save is dropped
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b1, 2'b01);
        step("save2 req");
        drive(1'b1, 2, 16'hFACE, 1'b1, 2, 1'b0, 0, 1'b0, 2'b00);
        step("busy write");
        run_idle("save2", 10);
        drive(1'b0, 0, '0, 1'b1, 2, 1'b0, 0, 1'b0, 2'b00);
        #3;
        chk("r2 after save", 32'(rd_data_a), 32'h1002);
        step("r2a");
        drive(1'b1, 2, 16'h7777, 1'b0, 0, 1'b0, 0, 1'b0, 2'b00);
        step("r2 overwrite");
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b1, 2'b10);
        step("restore2 req");
        run_idle("restore2", 11);
        drive(1'b0, 0, '0, 1'b1, 2, 1'b0, 0, 1'b0, 2'b00);
        #3;
        chk("r2 after restore", 32'(rd_data_a), 32'h1002);
        step("r2b");

        // Reserved op and request while busy
        busy_seen = 0; done_seen = 0;
        drive(1'b0, 0, '0, 1'b1, 1, 1'b0, 0, 1'b1, 2'b11);
        step("op11");
        run_idle("op11 idle", 4);
        chk("op11 busy", 32'(busy_seen), 32'd0);
        chk("op11 done", 32'(done_seen), 32'd0);
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b1, 2'b01);
        step("save3 req");
        run_idle("save3", 2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, '0, 1'b1, i, 1'b0, 0, 1'b1, 2'b10);
            step("req while busy");
        end
        run_idle("save3 tail", 8);
        chk("busy-req busy cycles", 32'(busy_seen), 32'd8);
        chk("busy-req done pulses", 32'(done_seen), 32'd1);

        // Reset during the 4th restore cycle aborts the copy
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b1, 2'b10);
        step("restore4 req");
        run_idle("restore4", 3);
        drive(1'b1, 5, 16'h9999, 1'b1, 5, 1'b1, 0, 1'b0, 2'b00);
        rst = 1'b0;
        #1;
        model_clear();
        chk("abort rd_a", 32'(rd_data_a), 32'h0);
        chk("abort rd_b", 32'(rd_data_b), 32'h0);
        chk("abort busy", 32'(ctx_busy), 32'h0);
        chk("abort done", 32'(ctx_done), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        busy_seen = 0; done_seen = 0;
        run_idle("post abort", 10);
        chk("abort no done", 32'(done_seen), 32'd0);
        drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b1, 2'b10);
        step("restore5 req");
        run_idle("restore5", 11);
        for (int i = 0; i < NUM_REGS; i++) begin
            drive(1'b0, 0, '0, 1'b1, i, 1'b0, 0, 1'b0, 2'b00);
            #3;
            chk($sformatf("zero r%0d", i), 32'(rd_data_a), 32'h0);
            step("zero");
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom), int'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom), int'($urandom_range(0, 7)),
                  1'($urandom), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0), 2'($urandom));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
